tff_mod_counter: RTL and testbench



---
 rtl/tff_pkg.sv | 29 ++
 rtl/tff_stage.sv | 24 ++
 rtl/tff_mod_counter.sv | 89 ++++++++
 tb/tb_tff_mod_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// Shared types and next-count rule for the toggle-stage modulo counter.
// Optional up/down counting is selected with the TFF_UPDOWN_EN macro.
package tff_pkg;

    localparam int unsigned TFF_MAX_WIDTH = 16;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Out-of-range counts always recover to zero.
    function automatic logic [31:0] next_count(
        input logic [31:0] q,
        input logic [31:0] modulus,
        input dir_e        dir
    );
        logic [31:0] r;
        if (q >= modulus) begin
            r = '0;
        end else if (dir == DIR_UP) begin
            r = (q == modulus - 32'd1) ? 32'd0 : q + 32'd1;
        end else begin
            r = (q == 32'd0) ? modulus - 32'd1 : q - 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tff_stage.sv
// Single toggle flip-flop with asynchronous active-low clear.
// QN is derived from the stored bit, never separately registered.
module tff_stage (
    input  logic CP,
    input  logic CD,
    input  logic T,
    output logic Q,
    output logic QN
);

    logic q_q;

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            q_q <= 1'b0;
        end else if (T) begin
            q_q <= ~q_q;
        end
    end

    assign Q  = q_q;
    assign QN = ~q_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Loadable modulo-N counter built from a column of tff_stage cells.
// Define TFF_UPDOWN_EN to add the UP port and down counting.
module tff_mod_counter
    import tff_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             CP,
    input  logic             CD,
    input  logic             EN,
    input  logic             LD,
`ifdef TFF_UPDOWN_EN
    input  logic             UP,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             TC,
    output logic             CO
);

    localparam logic [31:0] MOD  = 32'(MODULUS);
    localparam logic [31:0] LAST = MOD - 32'd1;

    dir_e             dir;
    logic [31:0]      q_ext;
    logic [31:0]      d_ext;
    logic [31:0]      nxt_ext;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] t;
    logic             hit;
    logic             wrap;
    logic             co_q;
    logic             co_d;
    logic             unused_nxt;

    always_comb begin
        dir = DIR_UP;
`ifdef TFF_UPDOWN_EN
        dir = UP ? DIR_UP : DIR_DOWN;
`endif
    end

    assign q_ext      = 32'(Q);
    assign d_ext      = 32'(D);
    assign nxt_ext    = next_count(q_ext, MOD, dir);
    assign unused_nxt = ^nxt_ext[31:WIDTH];

    assign hit = (dir == DIR_UP) ? (q_ext == LAST)
                                 : (q_ext == 32'd0);

    always_comb begin
        q_d = Q;
        if (LD) begin
            q_d = (d_ext < MOD) ? D : '0;
        end else if (EN) begin
            q_d = nxt_ext[WIDTH-1:0];
        end
    end

    // Each stage flips exactly where current and next count differ.
    assign t = Q ^ q_d;

    assign wrap = EN & ~LD & hit;
    assign TC   = CD & wrap;
    assign co_d = co_q ^ wrap;

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            co_q <= 1'b0;
        end else begin
            co_q <= co_d;
        end
    end

    assign CO = co_q;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
        tff_stage u_stage (
            .CP (CP),
            .CD (CD),
            .T  (t[i]),
            .Q  (Q[i]),
            .QN (QN[i])
        );
    end

endmodule

// File: tb/tb_tff_mod_counter.sv
// Scoreboard bench: two cascaded modulo-10 counters vs. an arithmetic model.
// Build with TFF_UPDOWN_EN defined to also exercise down counting.
module tb_tff_mod_counter;

    localparam int M = 10;

    logic       CP = 1'b0;
    logic       CD = 1'b0;
    logic       EN = 1'b0;
    logic       LD = 1'b0;
    logic [3:0] D  = '0;
`ifdef TFF_UPDOWN_EN
    logic       UP = 1'b1;
    logic       UP1 = 1'b1;
`endif
    logic [3:0] Q0, QN0, Q1, QN1;
    logic       TC0, CO0, TC1, CO1;
    logic       LD1 = 1'b0;
    logic [3:0] D1  = '0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int q0;
        int co0;
        int tc0;
        int q1;
        int co1;
        int tc1;
    } exp_t;

    exp_t sb[$];

    int m_q0 = 0, m_co0 = 0, m_q1 = 0, m_co1 = 0;

    always #5 CP = ~CP;

    tff_mod_counter #(.WIDTH(4), .MODULUS(M)) u_lo (
        .CP (CP), .CD (CD), .EN (EN), .LD (LD),
`ifdef TFF_UPDOWN_EN
        .UP (UP),
`endif
        .D  (D), .Q (Q0), .QN (QN0), .TC (TC0), .CO (CO0)
    );

    tff_mod_counter #(.WIDTH(4), .MODULUS(M)) u_hi (
        .CP (CP), .CD (CD), .EN (TC0), .LD (LD1),
`ifdef TFF_UPDOWN_EN
        .UP (UP1),
`endif
        .D  (D1), .Q (Q1), .QN (QN1), .TC (TC1), .CO (CO1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit term(input bit ld, input bit en,
                                input bit up, input int q);
        return en && !ld && (up ? (q == M - 1) : (q == 0));
    endfunction

    function automatic exp_t snap(input bit ld, input bit en, input bit up);
        exp_t e;
        e.q0  = m_q0;
        e.co0 = m_co0;
        e.tc0 = int'(term(ld, en, up, m_q0));
        e.q1  = m_q1;
        e.co1 = m_co1;
        e.tc1 = int'(term(1'b0, e.tc0 != 0, 1'b1, m_q1));
        return e;
    endfunction

    // One clocked cycle: drive on the falling edge, predict the next rise.
    task automatic step(input bit ld, input bit en,
                        input int d, input bit up);
        bit tc_pre;
        @(negedge CP);
        CD = 1'b1;
        LD = ld;
        EN = en;
        D  = 4'(d);
`ifdef TFF_UPDOWN_EN
        UP = up;
`endif
        tc_pre = term(ld, en, up, m_q0);
        if (ld) begin
            m_q0 = (d < M) ? d : 0;
        end else if (en) begin
            if (tc_pre) m_co0 ^= 1;
            m_q0 = up ? (m_q0 + 1) % M : (m_q0 + M - 1) % M;
        end
        if (tc_pre) begin
            if (m_q1 == M - 1) m_co1 ^= 1;
            m_q1 = (m_q1 + 1) % M;
        end
        sb.push_back(snap(ld, en, up));
    endtask

    // Clear between edges; the following rise happens with CD low.
    task automatic async_clear();
        exp_t e;
        @(negedge CP);
        LD = 1'b0;
        EN = 1'b1;
        #2 CD = 1'b0;
        #1;
        chk("clr_q0", int'(Q0), 0);
        chk("clr_qn0", int'(QN0), 15);
        chk("clr_co0", int'(CO0), 0);
        chk("clr_tc0", int'(TC0), 0);
        chk("clr_q1", int'(Q1), 0);
        m_q0 = 0; m_co0 = 0; m_q1 = 0; m_co1 = 0;
        e = '{default: 0};
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CP);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q0", int'(Q0), e.q0);
                chk("qn0", int'(QN0), (~e.q0) & 15);
                chk("co0", int'(CO0), e.co0);
                chk("tc0", int'(TC0), e.tc0);
                chk("q1", int'(Q1), e.q1);
                chk("co1", int'(CO1), e.co1);
                chk("tc1", int'(TC1), e.tc1);
            end
        end
    end

    initial begin : stim
        bit up;
        EN = 1'b1;
        repeat (3) @(posedge CP);
        #1;
        chk("rst_q", int'(Q0), 0);
        chk("rst_qn", int'(QN0), 15);
        chk("rst_co", int'(CO0), 0);
        chk("rst_tc", int'(TC0), 0);

        repeat (5) step(1'b0, 1'b1, 0, 1'b1);
        repeat (25) step(1'b0, 1'b1, 0, 1'b1);
        step(1'b1, 1'b0, 7, 1'b1);
        step(1'b1, 1'b0, 12, 1'b1);
        step(1'b1, 1'b0, 9, 1'b1);
        step(1'b1, 1'b1, 3, 1'b1);
        step(1'b1, 1'b0, 6, 1'b1);
        async_clear();
        repeat (100) step(1'b0, 1'b1, 0, 1'b1);
`ifdef TFF_UPDOWN_EN
        async_clear();
        repeat (3) step(1'b0, 1'b1, 0, 1'b0);
`endif
        for (int i = 0; i < 400; i++) begin
            up = 1'b1;
`ifdef TFF_UPDOWN_EN
            up = ($urandom_range(0, 3) != 0);
`endif
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 15)), up);
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge CP);
        #2;
        if (sb.size() > 0) chk("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
